data_in_w_to_n: RTL and testbench

//  Parametrised wide-to-narrow parallel unpacker feeding the tx serialiser path.

---
 rtl/data_in_w_to_n_if.sv | 41 ++++
 rtl/data_in_w_to_n.sv | 153 +++++++++++++++
 tb/tb_data_in_w_to_n.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/data_in_w_to_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_in_w_to_n_if
//  Description : Bundle of the signals between the wide-to-narrow unpacker and
//                its neighbours:
//                  word side  : in_data, in_valid, in_ready
//                  tx side    : next_req, manual_start, flush
//                  slice side : data_out, out_stb, word_done, underrun,
//                               slice_idx
//                master = the producer/tx side, slave = the unpacker itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface data_in_w_to_n_if #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 8
);
    localparam int IDX_W = $clog2(IN_W / OUT_W);

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             next_req;
    logic             manual_start;
    logic             flush;
    logic [OUT_W-1:0] data_out;
    logic             out_stb;
    logic             word_done;
    logic             underrun;
    logic [IDX_W-1:0] slice_idx;

    modport master (
        output in_data, in_valid, next_req, manual_start, flush,
        input  in_ready, data_out, out_stb, word_done, underrun, slice_idx
    );

    modport slave (
        input  in_data, in_valid, next_req, manual_start, flush,
        output in_ready, data_out, out_stb, word_done, underrun, slice_idx
    );
endinterface
`default_nettype wire

// File: rtl/data_in_w_to_n.sv
`default_nettype none
// ============================================================================
//  Module      : data_in_w_to_n
//  Description : Wide-to-narrow parallel unpacker for the tx serialiser path.
//                Takes one IN_W-bit word over valid/ready and releases it as
//                OUT_W-bit slices, one per rising edge of next_req or
//                manual_start. Supports LSB- or MSB-first order, cut-through
//                of the first slice, flush and underrun pulses.
//  Ports       : clk, rst (sync, active-high)
//                bus (slave modport): in_data/in_valid/in_ready word input,
//                next_req/manual_start/flush controls, data_out/out_stb/
//                word_done/underrun/slice_idx slice output.
//  Revision    : 1.0  initial release
// ============================================================================
module data_in_w_to_n #(
    parameter int IN_W      = 64,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    data_in_w_to_n_if.slave   bus
);
    localparam int c_nslice = IN_W / OUT_W;
    localparam int c_idx_w  = $clog2(c_nslice);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_nslice - 1);
    localparam logic [c_idx_w-1:0] c_one_idx  = c_idx_w'(1);
    // Bit position of slice 0 inside an incoming word (used for cut-through).
    localparam int c_pos0   = MSB_FIRST ? (c_nslice - 1) : 0;

    if (((IN_W % OUT_W) != 0) || (IN_W < 2 * OUT_W)) begin : g_bad_params
        $error("data_in_w_to_n: IN_W must be a multiple of OUT_W and >= 2*OUT_W");
    end

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [IN_W-1:0]      r_buf,       w_buf_nxt;
    logic [c_idx_w-1:0]   r_slice_idx, w_slice_idx_nxt;
    logic [OUT_W-1:0]     r_data_out,  w_data_out_nxt;
    logic                 r_out_stb,   w_out_stb_nxt;
    logic                 r_word_done, w_word_done_nxt;
    logic                 r_underrun,  w_underrun_nxt;
    logic                 r_req_d;
    logic                 r_start_d;

    logic                 w_req_edge;
    logic [OUT_W-1:0]     w_in_slice0;
    logic [OUT_W-1:0]     w_buf_slice [c_nslice];

    // Either request source starts a slice; both are level inputs, so only
    // their low-to-high transitions count.
    assign w_req_edge = (bus.next_req & ~r_req_d) | (bus.manual_start & ~r_start_d);

    // Reorder the held word into transmit order once, so the datapath is a
    // plain index by slice_idx regardless of MSB_FIRST.
    for (genvar gi = 0; gi < c_nslice; gi++) begin : g_slice
        localparam int c_pos = MSB_FIRST ? (c_nslice - 1 - gi) : gi;
        assign w_buf_slice[gi] = r_buf[c_pos*OUT_W +: OUT_W];
    end

    assign w_in_slice0 = bus.in_data[c_pos0*OUT_W +: OUT_W];

    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_slice_idx_nxt = r_slice_idx;
        w_data_out_nxt  = r_data_out;
        w_out_stb_nxt   = 1'b0;
        w_word_done_nxt = 1'b0;
        w_underrun_nxt  = 1'b0;

        if (bus.flush) begin
            // Drop the held word; data_out keeps its last slice.
            w_state_nxt     = ST_EMPTY;
            w_slice_idx_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (bus.in_valid) begin
                        w_buf_nxt   = bus.in_data;
                        w_state_nxt = ST_HOLD;
                        if (w_req_edge) begin
                            // Cut-through: first slice leaves in the same
                            // cycle the word is accepted.
                            w_data_out_nxt  = w_in_slice0;
                            w_out_stb_nxt   = 1'b1;
                            w_slice_idx_nxt = c_one_idx;
                        end else begin
                            w_slice_idx_nxt = '0;
                        end
                    end else if (w_req_edge) begin
                        w_underrun_nxt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_req_edge) begin
                        w_data_out_nxt = w_buf_slice[r_slice_idx];
                        w_out_stb_nxt  = 1'b1;
                        if (r_slice_idx == c_last_idx) begin
                            w_word_done_nxt = 1'b1;
                            w_slice_idx_nxt = '0;
                            w_state_nxt     = ST_EMPTY;
                        end else begin
                            w_slice_idx_nxt = r_slice_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = ST_EMPTY;
                    w_slice_idx_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_buf       <= '0;
            r_slice_idx <= '0;
            r_data_out  <= '0;
            r_out_stb   <= 1'b0;
            r_word_done <= 1'b0;
            r_underrun  <= 1'b0;
            r_req_d     <= 1'b0;
            r_start_d   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_slice_idx <= w_slice_idx_nxt;
            r_data_out  <= w_data_out_nxt;
            r_out_stb   <= w_out_stb_nxt;
            r_word_done <= w_word_done_nxt;
            r_underrun  <= w_underrun_nxt;
            r_req_d     <= bus.next_req;
            r_start_d   <= bus.manual_start;
        end
    end

    // A flush cycle never accepts a word, even when already EMPTY.
    assign bus.in_ready  = (r_state == ST_EMPTY) & ~bus.flush;
    assign bus.data_out  = r_data_out;
    assign bus.out_stb   = r_out_stb;
    assign bus.word_done = r_word_done;
    assign bus.underrun  = r_underrun;
    assign bus.slice_idx = r_slice_idx;

endmodule
`default_nettype wire

// File: tb/tb_data_in_w_to_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_in_w_to_n
//  Description : Directed self-checking bench for data_in_w_to_n. Two DUTs
//                (LSB-first and MSB-first) share one stimulus stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_data_in_w_to_n;
    localparam int IN_W  = 64;
    localparam int OUT_W = 8;
    localparam logic [63:0] c_w1 = 64'h0807_0605_0403_0201;
    localparam logic [63:0] c_w2 = 64'h8877_6655_4433_2211;

    logic            clk = 1'b0;
    logic            rst;
    logic [IN_W-1:0] in_data;
    logic            in_valid;
    logic            next_req;
    logic            manual_start;
    logic            flush;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_in_w_to_n_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_l ();
    data_in_w_to_n_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus_m ();

    assign bus_l.in_data      = in_data;
    assign bus_l.in_valid     = in_valid;
    assign bus_l.next_req     = next_req;
    assign bus_l.manual_start = manual_start;
    assign bus_l.flush        = flush;
    assign bus_m.in_data      = in_data;
    assign bus_m.in_valid     = in_valid;
    assign bus_m.next_req     = next_req;
    assign bus_m.manual_start = manual_start;
    assign bus_m.flush        = flush;

    data_in_w_to_n #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    data_in_w_to_n #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_data = c_w1; in_valid = 1'b1; next_req = 1'b1; manual_start = 1'b0; flush = 1'b0;
        tick();
        next_req = 1'b0; manual_start = 1'b1; in_valid = 1'b0;
        tick();
        if (bus_l.data_out !== 8'h00) begin $display("FAIL rst_data: got %h want 00", bus_l.data_out); miscompares++; end vectors++;
        if (bus_l.out_stb !== 1'b0) begin $display("FAIL rst_stb: got %b want 0", bus_l.out_stb); miscompares++; end vectors++;
        if (bus_l.word_done !== 1'b0) begin $display("FAIL rst_done: got %b want 0", bus_l.word_done); miscompares++; end vectors++;
        if (bus_l.underrun !== 1'b0) begin $display("FAIL rst_underrun: got %b want 0", bus_l.underrun); miscompares++; end vectors++;
        if (bus_l.slice_idx !== 3'd0) begin $display("FAIL rst_idx: got %0d want 0", bus_l.slice_idx); miscompares++; end vectors++;
        if (bus_m.data_out !== 8'h00) begin $display("FAIL rst_data_m: got %h want 00", bus_m.data_out); miscompares++; end vectors++;
        rst = 1'b0; manual_start = 1'b0; next_req = 1'b0; in_valid = 1'b0;
        tick();
        if (bus_l.in_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", bus_l.in_ready); miscompares++; end vectors++;
        if (bus_l.out_stb !== 1'b0) begin $display("FAIL rel_stb: got %b want 0", bus_l.out_stb); miscompares++; end vectors++;
    endtask

    task automatic test_lsb_first();
        int stb_cnt = 0;
        in_data = c_w1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (bus_l.in_ready !== 1'b0) begin $display("FAIL lsb_ready_hold: got %b want 0", bus_l.in_ready); miscompares++; end vectors++;
        if (bus_l.out_stb !== 1'b0) begin $display("FAIL lsb_load_stb: got %b want 0", bus_l.out_stb); miscompares++; end vectors++;
        for (int k = 0; k < 8; k++) begin
            next_req = 1'b1;
            tick();
            if (bus_l.out_stb === 1'b1) stb_cnt++;
            if (bus_l.data_out !== 8'(k + 1)) begin $display("FAIL lsb_data[%0d]: got %h want %h", k, bus_l.data_out, 8'(k + 1)); miscompares++; end vectors++;
            if (bus_l.word_done !== (k == 7)) begin $display("FAIL lsb_done[%0d]: got %b want %b", k, bus_l.word_done, (k == 7)); miscompares++; end vectors++;
            if (bus_l.slice_idx !== ((k == 7) ? 3'd0 : 3'(k + 1))) begin $display("FAIL lsb_idx[%0d]: got %0d", k, bus_l.slice_idx); miscompares++; end vectors++;
            if (bus_l.in_ready !== (k == 7)) begin $display("FAIL lsb_ready[%0d]: got %b want %b", k, bus_l.in_ready, (k == 7)); miscompares++; end vectors++;
            next_req = 1'b0;
            tick();
            if (bus_l.out_stb !== 1'b0 || bus_l.word_done !== 1'b0) begin $display("FAIL lsb_pulse[%0d]: stb %b done %b want 0 0", k, bus_l.out_stb, bus_l.word_done); miscompares++; end vectors++;
        end
        if (stb_cnt != 8) begin $display("FAIL lsb_stb_count: got %0d want 8", stb_cnt); miscompares++; end vectors++;
    endtask

    task automatic test_msb_first();
        in_data = c_w1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus_m.slice_idx !== 3'(k)) begin $display("FAIL msb_idx[%0d]: got %0d want %0d", k, bus_m.slice_idx, k); miscompares++; end vectors++;
            next_req = 1'b1;
            tick();
            if (bus_m.data_out !== 8'(8 - k)) begin $display("FAIL msb_data[%0d]: got %h want %h", k, bus_m.data_out, 8'(8 - k)); miscompares++; end vectors++;
            if (bus_m.out_stb !== 1'b1) begin $display("FAIL msb_stb[%0d]: got %b want 1", k, bus_m.out_stb); miscompares++; end vectors++;
            next_req = 1'b0;
            tick();
        end
        if (bus_m.slice_idx !== 3'd0) begin $display("FAIL msb_idx_wrap: got %0d want 0", bus_m.slice_idx); miscompares++; end vectors++;
    endtask

    task automatic test_cut_through();
        in_data = c_w1; in_valid = 1'b1; next_req = 1'b1;
        tick();
        if (bus_l.data_out !== 8'h01) begin $display("FAIL ct_data: got %h want 01", bus_l.data_out); miscompares++; end vectors++;
        if (bus_l.out_stb !== 1'b1) begin $display("FAIL ct_stb: got %b want 1", bus_l.out_stb); miscompares++; end vectors++;
        if (bus_l.slice_idx !== 3'd1) begin $display("FAIL ct_idx: got %0d want 1", bus_l.slice_idx); miscompares++; end vectors++;
        if (bus_m.data_out !== 8'h08) begin $display("FAIL ct_data_m: got %h want 08", bus_m.data_out); miscompares++; end vectors++;
        if (bus_l.in_ready !== 1'b0) begin $display("FAIL ct_ready: got %b want 0", bus_l.in_ready); miscompares++; end vectors++;
        next_req = 1'b0;
        // A different word offered while holding must be ignored.
        in_data = {8{8'hFF}};
        tick();
        for (int k = 1; k < 8; k++) begin
            next_req = 1'b1;
            tick();
            if (bus_l.data_out !== 8'(k + 1)) begin $display("FAIL ct_drain[%0d]: got %h want %h", k, bus_l.data_out, 8'(k + 1)); miscompares++; end vectors++;
            if (k == 7) begin
                if (bus_l.word_done !== 1'b1) begin $display("FAIL ct_done: got %b want 1", bus_l.word_done); miscompares++; end vectors++;
                in_valid = 1'b0;
            end
            next_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_underrun_and_hold();
        int stb_cnt = 0;
        next_req = 1'b1;
        tick();
        if (bus_l.underrun !== 1'b1) begin $display("FAIL ur_pulse: got %b want 1", bus_l.underrun); miscompares++; end vectors++;
        if (bus_l.out_stb !== 1'b0) begin $display("FAIL ur_stb: got %b want 0", bus_l.out_stb); miscompares++; end vectors++;
        if (bus_l.data_out !== 8'h08) begin $display("FAIL ur_data: got %h want 08", bus_l.data_out); miscompares++; end vectors++;
        if (bus_l.slice_idx !== 3'd0) begin $display("FAIL ur_idx: got %0d want 0", bus_l.slice_idx); miscompares++; end vectors++;
        next_req = 1'b0;
        tick();
        if (bus_l.underrun !== 1'b0) begin $display("FAIL ur_clear: got %b want 0", bus_l.underrun); miscompares++; end vectors++;
        in_data = c_w2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        next_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus_l.out_stb === 1'b1) stb_cnt++;
        end
        if (stb_cnt != 1) begin $display("FAIL hold_stb_count: got %0d want 1", stb_cnt); miscompares++; end vectors++;
        if (bus_l.data_out !== 8'h11) begin $display("FAIL hold_data: got %h want 11", bus_l.data_out); miscompares++; end vectors++;
        if (bus_l.slice_idx !== 3'd1) begin $display("FAIL hold_idx: got %0d want 1", bus_l.slice_idx); miscompares++; end vectors++;
        next_req = 1'b0;
        tick();
    endtask

    task automatic test_flush_and_reset();
        manual_start = 1'b1;
        tick();
        if (bus_l.data_out !== 8'h22 || bus_l.out_stb !== 1'b1) begin $display("FAIL ms_slice: got %h/%b want 22/1", bus_l.data_out, bus_l.out_stb); miscompares++; end vectors++;
        manual_start = 1'b0;
        tick();
        next_req = 1'b1;
        tick();
        if (bus_l.data_out !== 8'h33) begin $display("FAIL fl_pre_data: got %h want 33", bus_l.data_out); miscompares++; end vectors++;
        next_req = 1'b0;
        tick();
        flush = 1'b1; next_req = 1'b1;
        #1;
        if (bus_l.in_ready !== 1'b0) begin $display("FAIL fl_ready_low: got %b want 0", bus_l.in_ready); miscompares++; end vectors++;
        tick();
        if (bus_l.out_stb !== 1'b0) begin $display("FAIL fl_stb: got %b want 0", bus_l.out_stb); miscompares++; end vectors++;
        if (bus_l.data_out !== 8'h33) begin $display("FAIL fl_data_held: got %h want 33", bus_l.data_out); miscompares++; end vectors++;
        if (bus_l.slice_idx !== 3'd0) begin $display("FAIL fl_idx: got %0d want 0", bus_l.slice_idx); miscompares++; end vectors++;
        flush = 1'b0; next_req = 1'b0;
        #1;
        if (bus_l.in_ready !== 1'b1) begin $display("FAIL fl_ready: got %b want 1", bus_l.in_ready); miscompares++; end vectors++;
        in_data = c_w2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; next_req = 1'b1;
        tick();
        if (bus_l.data_out !== 8'h11) begin $display("FAIL fl_restart: got %h want 11", bus_l.data_out); miscompares++; end vectors++;
        if (bus_m.data_out !== 8'h88) begin $display("FAIL fl_restart_m: got %h want 88", bus_m.data_out); miscompares++; end vectors++;
        next_req = 1'b0;
        tick();
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        rst = 1'b1;
        tick();
        if (bus_l.data_out !== 8'h00) begin $display("FAIL mid_rst_data: got %h want 00", bus_l.data_out); miscompares++; end vectors++;
        if (bus_l.slice_idx !== 3'd0) begin $display("FAIL mid_rst_idx: got %0d want 0", bus_l.slice_idx); miscompares++; end vectors++;
        if (bus_l.in_ready !== 1'b1) begin $display("FAIL mid_rst_ready: got %b want 1", bus_l.in_ready); miscompares++; end vectors++;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_cut_through();
        test_underrun_and_hold();
        test_flush_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
